// File: rtl/axi_sram_rd_pkg.sv
// Shared types and constants for the AXI4 SRAM read slave.
// Holds the FSM state encoding, AXI response/burst codes and bus widths.
package axi_sram_rd_pkg;

  // AXI bus widths used by the read slave ports
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  // Read FSM: one SRAM access per beat, three cycles per beat minimum
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    DATA = 2'd3
  } state_e;

  localparam logic [RESP_W-1:0]  RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0]  RESP_SLVERR = 2'b10;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'd0;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'd1;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'd2;

  // Only 4-byte beats map onto the 32-bit SRAM word
  localparam logic [SIZE_W-1:0]  SIZE_4B     = 3'd2;

  // A burst the slave cannot serve: wrong beat size or a WRAP burst
  function automatic logic burst_is_bad(input logic [SIZE_W-1:0]  size,
                                        input logic [BURST_W-1:0] burst);
    return (size != SIZE_4B) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Address/beat bookkeeping for the AXI SRAM read slave.
// Latches the start word address, length and burst type on AR accept and
// steps the word address after every non-final R handshake.
module axi_rd_addr_gen
  import axi_sram_rd_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [AW-1:0]      load_addr,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [BURST_W-1:0] load_burst,
  input  logic               advance,
  output logic [AW-1:0]      addr,
  output logic               last
);

  logic [AW-1:0]      addr_q;
  logic [AW-1:0]      addr_next;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [BURST_W-1:0] burst_q;

  // Next beat address: FIXED repeats, INCR (and WRAP) steps modulo 2^AW
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // addr_next unassigned, which would infer a latch.
    addr_next = addr_q;
    if (burst_q != BURST_FIXED) begin
      addr_next = addr_q + AW'(1);
    end
  end

  // Burst registers: load on AR accept, step on each non-final R handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values; blocking here would create order-dependent races.
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      burst_q  <= BURST_INCR;
    end else if (load) begin
      addr_q   <= load_addr;
      len_q    <= load_len;
      beat_cnt <= '0;
      burst_q  <= load_burst;
    end else if (advance) begin
      addr_q   <= addr_next;
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  assign addr = addr_q;
  assign last = (beat_cnt == len_q);

endmodule

// File: rtl/axi_sram_read_slave.sv
// AXI4 read-channel slave in front of a single synchronous SRAM macro with
// one cycle of read latency. One outstanding burst, beats returned in order.
// Each beat costs RD (strobe SRAM), CAP (capture data) and DATA (hold until
// RREADY_S). Optional burst checking is enabled by defining
// AXI_SRAM_RD_ERRCHK_EN: bad size or WRAP bursts then return SLVERR beats
// with zero data and no SRAM access.
module axi_sram_read_slave
  import axi_sram_rd_pkg::*;
#(
  parameter int ID_W    = 8,
  parameter int AW_SRAM = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    ARID_S,
  input  logic [ADDR_W-1:0]  ARADDR_S,
  input  logic [LEN_W-1:0]   ARLEN_S,
  input  logic [SIZE_W-1:0]  ARSIZE_S,
  input  logic [BURST_W-1:0] ARBURST_S,
  input  logic               ARVALID_S,
  output logic               ARREADY_S,
  output logic [ID_W-1:0]    RID_S,
  output logic [DATA_W-1:0]  RDATA_S,
  output logic [RESP_W-1:0]  RRESP_S,
  output logic               RLAST_S,
  output logic               RVALID_S,
  input  logic               RREADY_S,
  output logic               sram_cs,
  output logic               sram_oe,
  output logic [AW_SRAM-1:0] sram_a,
  input  logic [DATA_W-1:0]  sram_do
);

  state_e              state_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [RESP_W-1:0]   rresp_q;
  logic                rlast_q;
  logic                rvalid_q;
  logic                cs_q;
  logic                bad_q;
  logic                bad_in;
  logic                ar_hs;
  logic                beat_adv;
  logic                beat_last;
  logic                unused_bits;

`ifdef AXI_SRAM_RD_ERRCHK_EN
  assign bad_in = burst_is_bad(ARSIZE_S, ARBURST_S);
`else
  assign bad_in = 1'b0;
`endif

  // Byte-lane bits, address bits above the SRAM and (without checking)
  // the beat size carry no meaning for this slave.
  assign unused_bits = ^{ARSIZE_S, ARADDR_S[ADDR_W-1:AW_SRAM+2], ARADDR_S[1:0]};

  // Gated by rst so the ready stays low while reset is held, even in IDLE
  assign ARREADY_S = rst && (state_q == IDLE);
  assign ar_hs     = ARREADY_S && ARVALID_S;
  assign beat_adv  = (state_q == DATA) && RREADY_S && !rlast_q;

  axi_rd_addr_gen #(
    .AW (AW_SRAM)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (ar_hs),
    .load_addr  (ARADDR_S[AW_SRAM+1:2]),
    .load_len   (ARLEN_S),
    .load_burst (ARBURST_S),
    .advance    (beat_adv),
    .addr       (sram_a),
    .last       (beat_last)
  );

  // Read FSM with registered R-channel outputs and SRAM strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      id_q     <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
      cs_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ARVALID_S) begin
            id_q    <= ARID_S;
            bad_q   <= bad_in;
            cs_q    <= !bad_in;
            state_q <= RD;
          end
        end
        RD: begin
          cs_q    <= 1'b0;
          state_q <= CAP;
        end
        CAP: begin
          rdata_q  <= bad_q ? '0 : sram_do;
          rresp_q  <= bad_q ? RESP_SLVERR : RESP_OKAY;
          rlast_q  <= beat_last;
          rvalid_q <= 1'b1;
          state_q  <= DATA;
        end
        DATA: begin
          if (RREADY_S) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              cs_q    <= !bad_q;
              state_q <= RD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RID_S    = id_q;
  assign RDATA_S  = rdata_q;
  assign RRESP_S  = rresp_q;
  assign RLAST_S  = rlast_q;
  assign RVALID_S = rvalid_q;
  assign sram_cs  = cs_q;
  assign sram_oe  = cs_q;

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Self-checking bench for axi_sram_read_slave: behavioural SRAM, a burst
// reference model computed from the AXI rules, directed and random bursts.
module tb_axi_sram_read_slave;

  localparam int ID_W    = 8;
  localparam int AW_SRAM = 14;

  logic               clk = 1'b0;
  logic               rst;
  logic [ID_W-1:0]    ARID_S;
  logic [31:0]        ARADDR_S;
  logic [3:0]         ARLEN_S;
  logic [2:0]         ARSIZE_S;
  logic [1:0]         ARBURST_S;
  logic               ARVALID_S;
  logic               ARREADY_S;
  logic [ID_W-1:0]    RID_S;
  logic [31:0]        RDATA_S;
  logic [1:0]         RRESP_S;
  logic               RLAST_S;
  logic               RVALID_S;
  logic               RREADY_S;
  logic               sram_cs;
  logic               sram_oe;
  logic [AW_SRAM-1:0] sram_a;
  logic [31:0]        sram_do = 32'h0;

  always #5 clk = ~clk;

  axi_sram_read_slave #(.ID_W(ID_W), .AW_SRAM(AW_SRAM)) dut (
    .clk(clk), .rst(rst),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_a(sram_a), .sram_do(sram_do)
  );

  // Behavioural SRAM with one cycle read latency
  logic [31:0] mem [0:(1<<AW_SRAM)-1];
  always @(posedge clk) if (sram_cs) sram_do <= mem[sram_a];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every SRAM strobe address and any oe/cs disagreement
  logic [AW_SRAM-1:0] cs_log[$];
  int oe_err = 0;
  always @(posedge clk) begin
    if (sram_cs === 1'b1) cs_log.push_back(sram_a);
    if (sram_oe !== sram_cs) oe_err++;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  got_id[$],   exp_id[$];
  logic [31:0] got_data[$], exp_data[$];
  logic [1:0]  got_resp[$], exp_resp[$];
  logic        got_last[$], exp_last[$];
  int unsigned got_edge[$];
  logic [AW_SRAM-1:0] exp_addr[$];
  int unsigned ar_edge;
  bit timed_out;
  int busy_ar_seen;

  // Reference model: beats and SRAM word addresses a burst must produce
  task automatic build_expect(input logic [7:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] burst,
                              input bit bad);
    logic [AW_SRAM-1:0] w0, w;
    exp_id.delete(); exp_data.delete(); exp_resp.delete();
    exp_last.delete(); exp_addr.delete();
    w0 = addr[AW_SRAM+1:2];
    for (int i = 0; i <= int'(len); i++) begin
      w = (burst == 2'd0) ? w0 : w0 + AW_SRAM'(i);
      exp_id.push_back(id);
      exp_data.push_back(bad ? 32'h0 : mem[w]);
      exp_resp.push_back(bad ? 2'b10 : 2'b00);
      exp_last.push_back(i == int'(len));
      if (!bad) exp_addr.push_back(w);
    end
  endtask

  // Issue one AR and collect all R beats; optionally keep a second AR pending
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input int rready_pct,
                           input bit hold_next);
    int guard;
    bit bad;
`ifdef AXI_SRAM_RD_ERRCHK_EN
    bad = (size != 3'd2) || (burst == 2'd2);
`else
    bad = 1'b0;
`endif
    build_expect(id, addr, len, burst, bad);
    got_id.delete(); got_data.delete(); got_resp.delete();
    got_last.delete(); got_edge.delete();
    timed_out = 0;
    busy_ar_seen = 0;
    @(negedge clk);
    cs_log.delete();
    ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARBURST_S = burst;
    ARSIZE_S = size; ARVALID_S = 1'b1;
    RREADY_S = (rready_pct >= 100);
    guard = 0;
    while (!ARREADY_S && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ARREADY_S) begin
      timed_out = 1;
      ARVALID_S = 1'b0;
      return;
    end
    ar_edge = cyc + 1;
    @(negedge clk);
    if (hold_next) begin
      ARID_S = 8'h55; ARADDR_S = 32'h0000_0040; ARLEN_S = 4'd0;
      ARBURST_S = 2'd1; ARSIZE_S = 3'd2;
    end else begin
      ARVALID_S = 1'b0;
    end
    guard = 0;
    forever begin
      if (rready_pct < 100) RREADY_S = ($urandom_range(0, 99) < rready_pct);
      if (hold_next && ARREADY_S) busy_ar_seen++;
      if (RVALID_S && RREADY_S) begin
        got_id.push_back(RID_S); got_data.push_back(RDATA_S);
        got_resp.push_back(RRESP_S); got_last.push_back(RLAST_S);
        got_edge.push_back(cyc + 1);
        if (RLAST_S) begin
          @(negedge clk);
          break;
        end
      end
      guard++;
      if (guard > 400) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ARREADY_S, RVALID_S, RLAST_S, RRESP_S, RID_S, RDATA_S} !== '0) begin
      errors++;
      $display("FAIL reset_r_outputs got ar=%b rv=%b rl=%b resp=%h id=%h data=%h want all zero",
               ARREADY_S, RVALID_S, RLAST_S, RRESP_S, RID_S, RDATA_S);
    end
    checks++;
    if ({sram_cs, sram_oe, sram_a} !== '0) begin
      errors++;
      $display("FAIL reset_sram got cs=%b oe=%b a=%h want 0", sram_cs, sram_oe, sram_a);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ARREADY_S, RVALID_S} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release got arready=%b rvalid=%b want 1 0", ARREADY_S, RVALID_S);
    end
  endtask

  task automatic test_single();
    mem[4] = 32'hDEAD_BEEF;
    run_burst(8'h0A, 32'h0000_0010, 4'd0, 2'd1, 3'd2, 100, 0);
    checks++;
    if (timed_out || got_data.size() != 1) begin
      errors++;
      $display("FAIL single_count got beats=%0d timeout=%0d want 1 0", got_data.size(), timed_out);
    end else begin
      checks++;
      if ({got_id[0], got_data[0], got_resp[0], got_last[0]} !== {8'h0A, 32'hDEAD_BEEF, 2'b00, 1'b1}) begin
        errors++;
        $display("FAIL single_beat got id=%h data=%h resp=%h last=%b want 0a deadbeef 0 1",
                 got_id[0], got_data[0], got_resp[0], got_last[0]);
      end
      checks++;
      if (got_edge[0] - ar_edge != 3) begin
        errors++;
        $display("FAIL single_latency got %0d want 3", got_edge[0] - ar_edge);
      end
    end
    checks++;
    if (cs_log.size() != 1 || cs_log[0] !== 14'd4) begin
      errors++;
      $display("FAIL single_sram_a got n=%0d want one strobe at 0004", cs_log.size());
    end
  endtask

  task automatic test_incr_wrap_around();
    run_burst(8'h11, 32'hABC0_0000 | (32'h3FFE << 2) | 32'h3, 4'd3, 2'd1, 3'd2, 100, 0);
    checks++;
    if (timed_out || got_data.size() != 4) begin
      errors++;
      $display("FAIL wrap_count got beats=%0d timeout=%0d want 4 0", got_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({got_id[i], got_data[i], got_resp[i], got_last[i]} !==
            {exp_id[i], exp_data[i], exp_resp[i], exp_last[i]}) begin
          errors++;
          $display("FAIL wrap_beat%0d got %h %h %h %b want %h %h %h %b", i,
                   got_id[i], got_data[i], got_resp[i], got_last[i],
                   exp_id[i], exp_data[i], exp_resp[i], exp_last[i]);
        end
        checks++;
        if (got_edge[i] - ((i == 0) ? ar_edge : got_edge[i-1]) != 3) begin
          errors++;
          $display("FAIL wrap_spacing%0d got %0d want 3", i,
                   got_edge[i] - ((i == 0) ? ar_edge : got_edge[i-1]));
        end
      end
    end
    checks++;
    if (cs_log != '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001}) begin
      errors++;
      $display("FAIL wrap_sram_a got n=%0d want 3ffe 3fff 0000 0001", cs_log.size());
    end
  endtask

  task automatic test_fixed();
    run_burst(8'h22, 32'h0000_0014, 4'd2, 2'd0, 3'd2, 100, 0);
    checks++;
    if (timed_out || got_data.size() != 3) begin
      errors++;
      $display("FAIL fixed_count got beats=%0d timeout=%0d want 3 0", got_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({got_data[i], got_last[i]} !== {mem[5], i == 2}) begin
          errors++;
          $display("FAIL fixed_beat%0d got %h %b want %h %b", i, got_data[i], got_last[i], mem[5], i == 2);
        end
      end
    end
    checks++;
    if (cs_log != '{14'd5, 14'd5, 14'd5}) begin
      errors++;
      $display("FAIL fixed_sram_a got n=%0d want three strobes at 0005", cs_log.size());
    end
  endtask

  task automatic test_stall();
    logic [42:0] snap;
    bit stable;
    int guard;
    int cs_n;
    build_expect(8'h3C, 32'h0000_0400, 4'd1, 2'd1, 1'b0);
    @(negedge clk);
    cs_log.delete();
    ARID_S = 8'h3C; ARADDR_S = 32'h0000_0400; ARLEN_S = 4'd1; ARBURST_S = 2'd1;
    ARSIZE_S = 3'd2; ARVALID_S = 1'b1; RREADY_S = 1'b0;
    guard = 0;
    while (!ARREADY_S && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    ARVALID_S = 1'b0;
    guard = 0;
    while (!RVALID_S && guard < 20) begin @(negedge clk); guard++; end
    snap = {RID_S, RDATA_S, RRESP_S, RLAST_S};
    checks++;
    if (snap !== {exp_id[0], exp_data[0], exp_resp[0], exp_last[0]}) begin
      errors++;
      $display("FAIL stall_first got %h want %h", snap, {exp_id[0], exp_data[0], exp_resp[0], exp_last[0]});
    end
    cs_n = cs_log.size();
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if ({RID_S, RDATA_S, RRESP_S, RLAST_S} !== snap || RVALID_S !== 1'b1 ||
          ARREADY_S !== 1'b0 || sram_cs !== 1'b0) stable = 0;
    end
    checks++;
    if (!stable || cs_log.size() != cs_n) begin
      errors++;
      $display("FAIL stall_hold got stable=%0d strobes=%0d want 1 %0d", stable, cs_log.size(), cs_n);
    end
    RREADY_S = 1'b1;
    @(negedge clk);
    checks++;
    if (RVALID_S !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept got rvalid=%b want 0", RVALID_S);
    end
    guard = 0;
    while (!RVALID_S && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if ({RID_S, RDATA_S, RRESP_S, RLAST_S} !== {exp_id[1], exp_data[1], exp_resp[1], exp_last[1]}) begin
      errors++;
      $display("FAIL stall_second got %h %h %h %b want %h %h %h %b", RID_S, RDATA_S, RRESP_S, RLAST_S,
               exp_id[1], exp_data[1], exp_resp[1], exp_last[1]);
    end
    @(negedge clk);
    RREADY_S = 1'b0;
    checks++;
    if (ARREADY_S !== 1'b1) begin
      errors++;
      $display("FAIL stall_idle got arready=%b want 1", ARREADY_S);
    end
  endtask

  task automatic test_busy_ar();
    int guard;
    run_burst(8'h21, 32'h0000_0200, 4'd3, 2'd1, 3'd2, 100, 1);
    checks++;
    if (timed_out || got_id.size() != 4) begin
      errors++;
      $display("FAIL busy_count got beats=%0d timeout=%0d want 4 0", got_id.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({got_id[i], got_data[i], got_last[i]} !== {8'h21, exp_data[i], exp_last[i]}) begin
          errors++;
          $display("FAIL busy_beat%0d got %h %h %b want 21 %h %b", i, got_id[i], got_data[i],
                   got_last[i], exp_data[i], exp_last[i]);
        end
      end
    end
    checks++;
    if (busy_ar_seen != 0 || ARREADY_S !== 1'b1) begin
      errors++;
      $display("FAIL busy_arready got early=%0d now=%b want 0 1", busy_ar_seen, ARREADY_S);
    end
    @(negedge clk);
    ARVALID_S = 1'b0;
    RREADY_S = 1'b1;
    guard = 0;
    while (!RVALID_S && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if ({RID_S, RDATA_S, RLAST_S} !== {8'h55, mem[16], 1'b1}) begin
      errors++;
      $display("FAIL busy_second got %h %h %b want 55 %h 1", RID_S, RDATA_S, RLAST_S, mem[16]);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] len;
    logic [2:0] size;
    for (int n = 0; n < 25; n++) begin
      len  = 4'($urandom_range(0, 15));
      size = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      run_burst(8'($urandom), $urandom, len, 2'($urandom_range(0, 2)), size,
                int'($urandom_range(30, 100)), 0);
      checks++;
      if (timed_out || got_data.size() != exp_data.size()) begin
        errors++;
        $display("FAIL rand%0d_count got beats=%0d timeout=%0d want %0d", n,
                 got_data.size(), timed_out, exp_data.size());
      end else begin
        for (int i = 0; i < exp_data.size(); i++) begin
          checks++;
          if ({got_id[i], got_data[i], got_resp[i], got_last[i]} !==
              {exp_id[i], exp_data[i], exp_resp[i], exp_last[i]}) begin
            errors++;
            $display("FAIL rand%0d_beat%0d got %h %h %h %b want %h %h %h %b", n, i,
                     got_id[i], got_data[i], got_resp[i], got_last[i],
                     exp_id[i], exp_data[i], exp_resp[i], exp_last[i]);
          end
        end
      end
      checks++;
      if (cs_log != exp_addr) begin
        errors++;
        $display("FAIL rand%0d_sram_a got n=%0d want n=%0d", n, cs_log.size(), exp_addr.size());
      end
    end
  endtask

`ifdef AXI_SRAM_RD_ERRCHK_EN
  task automatic test_errchk();
    run_burst(8'h66, 32'h0000_0100, 4'd3, 2'd1, 3'd1, 100, 0);
    checks++;
    if (timed_out || got_data.size() != 4 || cs_log.size() != 0) begin
      errors++;
      $display("FAIL errchk_size got beats=%0d strobes=%0d want 4 0", got_data.size(), cs_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({got_data[i], got_resp[i], got_last[i]} !== {32'h0, 2'b10, i == 3}) begin
          errors++;
          $display("FAIL errchk_beat%0d got %h %h %b want 0 2 %b", i, got_data[i], got_resp[i],
                   got_last[i], i == 3);
        end
      end
    end
    run_burst(8'h67, 32'h0000_0100, 4'd1, 2'd2, 3'd2, 100, 0);
    checks++;
    if (got_resp.size() != 2 || got_resp[1] !== 2'b10 || cs_log.size() != 0) begin
      errors++;
      $display("FAIL errchk_wrap got beats=%0d strobes=%0d want 2 SLVERR beats, 0 strobes",
               got_resp.size(), cs_log.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    int rv_seen;
    int guard;
    @(negedge clk);
    ARID_S = 8'h77; ARADDR_S = 32'h0000_0800; ARLEN_S = 4'd7; ARBURST_S = 2'd1;
    ARSIZE_S = 3'd2; ARVALID_S = 1'b1; RREADY_S = 1'b1;
    guard = 0;
    while (!ARREADY_S && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    ARVALID_S = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({RVALID_S, ARREADY_S, sram_cs} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_assert got rvalid=%b arready=%b cs=%b want 0 0 0", RVALID_S, ARREADY_S, sram_cs);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ARREADY_S !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release got arready=%b want 1", ARREADY_S);
    end
    cs_log.delete();
    rv_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (RVALID_S !== 1'b0) rv_seen++;
    end
    checks++;
    if (rv_seen != 0 || cs_log.size() != 0) begin
      errors++;
      $display("FAIL midreset_quiet got rvalid_cycles=%0d strobes=%0d want 0 0", rv_seen, cs_log.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = 3'd2; ARBURST_S = 2'd1;
    ARVALID_S = 1'b0; RREADY_S = 1'b0;
    for (int i = 0; i < (1 << AW_SRAM); i++) mem[i] = $urandom;
    test_reset();
    test_single();
    test_incr_wrap_around();
    test_fixed();
    test_stall();
    test_busy_ar();
    test_random();
`ifdef AXI_SRAM_RD_ERRCHK_EN
    test_errchk();
`endif
    test_reset_mid();
    checks++;
    if (oe_err != 0) begin
      errors++;
      $display("FAIL sram_oe_tracks_cs got %0d disagreeing cycles want 0", oe_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
